// File: rtl/dataslot_cmd_arbiter.sv
// dataslot_cmd_arbiter: round-robin share of the bridge_core dataslot command channel with ack/done/timeout sequencing
//   clk_74a, reset_n             : clock, async active-low reset
//   req_valid/op/slot_id/...     : per-requester packed command fields, held until req_ready
//   req_ready, req_done/error    : one-hot accept pulse, one-hot completion pulse with failure flag
//   cmd_* / cmd_ack/done/status  : latched command to the host and its handshake
//   busy, grant_idx              : not idle, current or last grantee
module dataslot_cmd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd74_250_000,
  localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk_74a,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [2*NUM_REQ-1:0]    req_op,
  input  logic [16*NUM_REQ-1:0]   req_slot_id,
  input  logic [32*NUM_REQ-1:0]   req_slot_offset,
  input  logic [32*NUM_REQ-1:0]   req_bridge_addr,
  input  logic [32*NUM_REQ-1:0]   req_length,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      req_done,
  output logic                    req_error,
  output logic                    cmd_valid,
  output logic [1:0]              cmd_op,
  output logic [15:0]             cmd_slot_id,
  output logic [31:0]             cmd_slot_offset,
  output logic [31:0]             cmd_bridge_addr,
  output logic [31:0]             cmd_length,
  input  logic                    cmd_ack,
  input  logic                    cmd_done,
  input  logic [2:0]              cmd_status,
  output logic                    busy,
  output logic [GW-1:0]           grant_idx
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, COMPLETE} state_t;
  state_t state;
  logic [GW-1:0] rr_ptr;
  logic [31:0] cnt;
  logic err, hit, to;
  int sel;
  always_comb begin
    hit = 1'b0;
    sel = 0;
    // scan downward so the requester closest above rr_ptr wins last
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        hit = 1'b1;
        sel = (int'(rr_ptr) + k) % NUM_REQ;
      end
  end
  assign to = (TIMEOUT_CYCLES != 32'd0) && (cnt == TIMEOUT_CYCLES - 32'd1);
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_idx <= '0;
      cnt <= '0;
      err <= 1'b0;
      busy <= 1'b0;
      req_ready <= '0;
      req_done <= '0;
      req_error <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_op <= '0;
      cmd_slot_id <= '0;
      cmd_slot_offset <= '0;
      cmd_bridge_addr <= '0;
      cmd_length <= '0;
    end else begin
      req_ready <= '0;
      req_done <= '0;
      req_error <= 1'b0;
      case (state)
        IDLE: if (hit) begin
          grant_idx <= GW'(sel);
          rr_ptr <= GW'((sel + 1) % NUM_REQ);
          req_ready <= NUM_REQ'(1) << sel;
          cmd_op <= req_op[sel*2 +: 2];
          cmd_slot_id <= req_slot_id[sel*16 +: 16];
          cmd_slot_offset <= req_slot_offset[sel*32 +: 32];
          cmd_bridge_addr <= req_bridge_addr[sel*32 +: 32];
          cmd_length <= req_length[sel*32 +: 32];
          cnt <= '0;
          busy <= 1'b1;
          // reserved op never reaches the host
          err <= req_op[sel*2 +: 2] == 2'd3;
          cmd_valid <= req_op[sel*2 +: 2] != 2'd3;
          state <= req_op[sel*2 +: 2] == 2'd3 ? COMPLETE : ISSUE;
        end
        ISSUE: begin
          cnt <= cnt == '1 ? cnt : cnt + 32'd1;
          // done without ack counts as an implicit ack
          if (cmd_done) begin
            err <= cmd_status != 3'd0;
            cmd_valid <= 1'b0;
            state <= COMPLETE;
          end else if (cmd_ack) begin
            cnt <= '0;
            cmd_valid <= 1'b0;
            state <= WAIT_DONE;
          end else if (to) begin
            err <= 1'b1;
            cmd_valid <= 1'b0;
            state <= COMPLETE;
          end
        end
        WAIT_DONE: begin
          cnt <= cnt == '1 ? cnt : cnt + 32'd1;
          if (cmd_done || to) begin
            err <= cmd_done ? cmd_status != 3'd0 : 1'b1;
            state <= COMPLETE;
          end
        end
        default: begin
          req_done <= NUM_REQ'(1) << grant_idx;
          req_error <= err;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dataslot_cmd_arbiter.sv
// tb_dataslot_cmd_arbiter: randomized transaction-level check of dataslot_cmd_arbiter
module tb_dataslot_cmd_arbiter;
  localparam int N = 4;
  localparam int T = 8;
  logic clk_74a = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [2*N-1:0] req_op = '0;
  logic [16*N-1:0] req_slot_id = '0;
  logic [32*N-1:0] req_slot_offset = '0, req_bridge_addr = '0, req_length = '0;
  logic [N-1:0] req_ready, req_done;
  logic req_error, cmd_valid, busy;
  logic [1:0] cmd_op;
  logic [15:0] cmd_slot_id;
  logic [31:0] cmd_slot_offset, cmd_bridge_addr, cmd_length;
  logic cmd_ack = 1'b0, cmd_done = 1'b0;
  logic [2:0] cmd_status = '0;
  logic [1:0] grant_idx;
  int checks = 0, errors = 0, rr = 0;
  logic [1:0] f_op[N];
  logic [15:0] f_id[N];
  logic [31:0] f_off[N], f_addr[N], f_len[N];

  dataslot_cmd_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(32'(T))) dut (
    .clk_74a(clk_74a), .reset_n(reset_n), .req_valid(req_valid), .req_op(req_op),
    .req_slot_id(req_slot_id), .req_slot_offset(req_slot_offset),
    .req_bridge_addr(req_bridge_addr), .req_length(req_length),
    .req_ready(req_ready), .req_done(req_done), .req_error(req_error),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_slot_id(cmd_slot_id),
    .cmd_slot_offset(cmd_slot_offset), .cmd_bridge_addr(cmd_bridge_addr),
    .cmd_length(cmd_length), .cmd_ack(cmd_ack), .cmd_done(cmd_done),
    .cmd_status(cmd_status), .busy(busy), .grant_idx(grant_idx)
  );

  always #5 clk_74a = ~clk_74a;

  task automatic step;
    @(posedge clk_74a);
    #1;
  endtask

  task automatic rand_fields(input int op);
    for (int i = 0; i < N; i++) begin
      f_op[i] = op < 0 ? 2'($urandom_range(0, 3)) : 2'(op);
      f_id[i] = 16'($urandom);
      f_off[i] = $urandom;
      f_addr[i] = $urandom;
      f_len[i] = $urandom;
    end
  endtask

  task automatic apply_fields;
    for (int i = 0; i < N; i++) begin
      req_op[2*i +: 2] = f_op[i];
      req_slot_id[16*i +: 16] = f_id[i];
      req_slot_offset[32*i +: 32] = f_off[i];
      req_bridge_addr[32*i +: 32] = f_addr[i];
      req_length[32*i +: 32] = f_len[i];
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  function automatic logic [207:0] all_outs();
    return {req_ready, req_done, req_error, cmd_valid, cmd_op, cmd_slot_id, cmd_slot_offset,
            cmd_bridge_addr, cmd_length, busy, grant_idx};
  endfunction

  // mode 0: ack at ISSUE cycle a, done at WAIT cycle w; mode 1: ack+done at a; mode 2: done alone at a
  task automatic txn(input string nm, input logic [N-1:0] mask, input int mode, input int a,
                     input int w, input logic [2:0] st);
    int g, issue_n, wait_n, dcyc, vcnt, bad_f, bad_d;
    logic exp_err, busy0;
    apply_fields();
    req_valid = mask;
    g = pick(mask, rr);
    step();
    checks++;
    if (req_ready !== N'(1) << g)
      begin errors++; $display("FAIL %s ready: got %b expected %b", nm, req_ready, N'(1) << g); end
    checks++;
    if (grant_idx !== 2'(g))
      begin errors++; $display("FAIL %s grant_idx: got %0d expected %0d", nm, grant_idx, g); end
    req_valid = '0;
    rr = (g + 1) % N;
    if (f_op[g] == 2'd3) begin issue_n = 0; wait_n = 0; exp_err = 1'b1; end
    else if (a >= T) begin issue_n = T; wait_n = 0; exp_err = 1'b1; end
    else if (mode == 0) begin
      issue_n = a + 1;
      wait_n = w < T ? w + 1 : T;
      exp_err = w < T ? st != 3'd0 : 1'b1;
    end else begin issue_n = a + 1; wait_n = 0; exp_err = st != 3'd0; end
    dcyc = issue_n + wait_n + 1;
    vcnt = 0; bad_f = 0; bad_d = 0; busy0 = busy;
    for (int k = 0; k <= dcyc + 1; k++) begin
      if (cmd_valid) begin
        vcnt++;
        if (cmd_op !== f_op[g] || cmd_slot_id !== f_id[g] || cmd_slot_offset !== f_off[g] ||
            cmd_bridge_addr !== f_addr[g] || cmd_length !== f_len[g]) bad_f++;
      end
      if (k == dcyc) begin
        checks++;
        if (req_done !== N'(1) << g || req_error !== exp_err) begin
          errors++;
          $display("FAIL %s done: got done=%b err=%b expected done=%b err=%b", nm, req_done,
                   req_error, N'(1) << g, exp_err);
        end
      end else if (req_done !== '0) bad_d++;
      cmd_ack = f_op[g] != 2'd3 && a < T && k == a && mode != 2;
      cmd_done = f_op[g] != 2'd3 && a < T &&
                 ((k == a && mode != 0) || (mode == 0 && w < T && k == issue_n + w));
      cmd_status = cmd_done ? st : 3'($urandom);
      step();
    end
    cmd_ack = 1'b0;
    cmd_done = 1'b0;
    checks++;
    if (vcnt != issue_n)
      begin errors++; $display("FAIL %s cmd_valid cycles: got %0d expected %0d", nm, vcnt, issue_n); end
    checks++;
    if (bad_f != 0)
      begin errors++; $display("FAIL %s cmd fields: %0d bad cycles expected 0", nm, bad_f); end
    checks++;
    if (bad_d != 0)
      begin errors++; $display("FAIL %s stray req_done: %0d cycles expected 0", nm, bad_d); end
    checks++;
    if (busy0 !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL %s busy: got %b/%b expected 1/0", nm, busy0, busy); end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (all_outs() !== '0) begin errors++; $display("FAIL reset outputs: got %h expected 0", all_outs()); end
    @(negedge clk_74a);
    reset_n = 1'b1;
    step();
    checks++;
    if (all_outs() !== '0) begin errors++; $display("FAIL idle outputs: got %h expected 0", all_outs()); end
    rr = 0;
  endtask

  task automatic test_round_robin;
    int n, last, exp;
    n = 0; last = 0; exp = rr;
    rand_fields(0);
    apply_fields();
    req_valid = '1;
    cmd_ack = 1'b1;
    cmd_done = 1'b1;
    cmd_status = 3'd0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      step();
      if (req_ready !== '0) begin
        checks++;
        if (req_ready !== N'(1) << exp)
          begin errors++; $display("FAIL rr grant %0d: got %b expected %b", n, req_ready, N'(1) << exp); end
        if (n > 0) begin
          checks++;
          if (c - last != 3)
            begin errors++; $display("FAIL rr spacing: got %0d expected 3", c - last); end
        end
        last = c;
        exp = (exp + 1) % N;
        n++;
        if (n == 5) req_valid = '0;
      end
    end
    checks++;
    if (n != 5) begin errors++; $display("FAIL rr grant count: got %0d expected 5", n); end
    rr = exp;
    repeat (3) step();
    cmd_ack = 1'b0;
    cmd_done = 1'b0;
    step();
  endtask

  task automatic test_single_read;
    rand_fields(0);
    f_id[0] = 16'h0003;
    f_len[0] = 32'h200;
    txn("single_read", 4'b0001, 0, 3, 5, 3'd0);
  endtask

  task automatic test_error_status;
    rand_fields(1);
    txn("error_status", 4'b0010, 0, 1, 2, 3'd2);
  endtask

  task automatic test_timeouts;
    rand_fields(0);
    txn("timeout_ack", 4'b0100, 0, T, 0, 3'd0);
    rand_fields(1);
    txn("timeout_done", 4'b1000, 0, 2, T, 3'd0);
  endtask

  task automatic test_reserved;
    rand_fields(3);
    txn("reserved_op", 4'b0100, 0, 0, 0, 3'd0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      rand_fields($urandom_range(0, 4) == 0 ? -1 : int'($urandom_range(0, 2)));
      txn("random", N'($urandom_range(1, 15)), int'($urandom_range(0, 2)), int'($urandom_range(0, 9)),
          int'($urandom_range(0, 9)), $urandom_range(0, 3) == 0 ? 3'($urandom_range(1, 7)) : 3'd0);
    end
  endtask

  task automatic test_reset_mid;
    rand_fields(0);
    apply_fields();
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    cmd_ack = 1'b1;
    step();
    cmd_ack = 1'b0;
    step();
    checks++;
    if (busy !== 1'b1 || cmd_valid !== 1'b0)
      begin errors++; $display("FAIL wait_done entry: got busy=%b valid=%b expected 1/0", busy, cmd_valid); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (all_outs() !== '0) begin errors++; $display("FAIL async reset: got %h expected 0", all_outs()); end
    @(negedge clk_74a);
    reset_n = 1'b1;
    step();
    cmd_done = 1'b1;
    cmd_status = 3'd0;
    step();
    cmd_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (req_done !== '0 || busy !== 1'b0)
        begin errors++; $display("FAIL stale done: got done=%b busy=%b expected 0/0", req_done, busy); end
      step();
    end
    rr = 0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_error_status();
    test_timeouts();
    test_reserved();
    test_random();
    test_reset_mid();
    test_single_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
